vga_sync_gen: RTL and testbench

- 640x480@60 Hz VGA timing generator; consumes the 25 MHz pixel rate produced by the clock divider stage.
- Single 50 MHz clock domain. Pixel rate is applied as a one-cycle enable (pix_tick), never used as a clock.
- Produces hsync, vsync, the active-video flag, the current pixel coordinates and a frame-start strobe for the pixel generator downstream.

---
 rtl/vga_sync_gen.sv | 112 +++++++++++
 tb/tb_vga_sync_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: counters, registered syncs, active-video flag and frame-start strobe.
// Optional VGA_INTERNAL_TICK_EN: derive the pixel tick from an internal toggle flop instead of pix_tick.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic             tick_c;
    logic [CNT_W-1:0] x_nxt_c;
    logic [CNT_W-1:0] y_nxt_c;
    logic             hsync_nxt_c;
    logic             vsync_nxt_c;
    logic             video_nxt_c;

`ifdef VGA_INTERNAL_TICK_EN
    // Toggle flop: low on the first edge after clr, high on the second.
    logic tick_q;
    logic unused_pix_tick;

    assign unused_pix_tick = pix_tick;
    assign tick_c          = tick_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
        end
    end
`else
    assign tick_c = pix_tick;
`endif

    // Next counter position; holds when no tick.
    always_comb begin
        x_nxt_c = pixel_x;
        y_nxt_c = pixel_y;
        if (tick_c) begin
            if (pixel_x == X_LAST) begin
                x_nxt_c = '0;
                y_nxt_c = (pixel_y == Y_LAST) ? '0 : pixel_y + CNT_W'(1);
            end else begin
                x_nxt_c = pixel_x + CNT_W'(1);
            end
        end
    end

    // Decode from the next position so registered flags line up with the registered counters.
    always_comb begin
        hsync_nxt_c = 1'b1;
        vsync_nxt_c = 1'b1;
        video_nxt_c = 1'b0;
        if ((x_nxt_c >= HS_START) && (x_nxt_c <= HS_END)) begin
            hsync_nxt_c = 1'b0;
        end
        if ((y_nxt_c >= VS_START) && (y_nxt_c <= VS_END)) begin
            vsync_nxt_c = 1'b0;
        end
        if ((x_nxt_c < X_VIS) && (y_nxt_c < Y_VIS)) begin
            video_nxt_c = 1'b1;
        end
    end

    // Reset parks the counters on the last position so the first tick lands on (0,0).
    always_ff @(posedge clk) begin
        if (clr) begin
            pixel_x     <= X_LAST;
            pixel_y     <= Y_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_nxt_c;
            pixel_y     <= y_nxt_c;
            hsync       <= hsync_nxt_c;
            vsync       <= vsync_nxt_c;
            video_on    <= video_nxt_c;
            frame_start <= tick_c && (x_nxt_c == '0) && (y_nxt_c == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: full-size instance plus a reduced-timing instance for whole frames.
module tb_vga_sync_gen;

    // Reduced timing for the second instance: 15 x 13 totals, 195 ticks per frame.
    localparam int BHD = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVD = 6, BVF = 2, BVS = 2, BVB = 3;
    localparam int AHT = 800, AVT = 525;
    localparam int BHT = BHD + BHF + BHS + BHB;
    localparam int BVT = BVD + BVF + BVS + BVB;

    logic       clk = 1'b0;
    logic       clr;
    logic       pix_tick;
    logic       a_hs, a_vs, a_vo, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_vo, b_fs;
    logic [9:0] b_x, b_y;

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    always #10 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .clr(clr), .pix_tick(pix_tick),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
        .pixel_x(a_x), .pixel_y(a_y), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB), .CNT_W(10)
    ) dut_b (
        .clk(clk), .clr(clr), .pix_tick(pix_tick),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
        .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs)
    );

    // Model: number of ticks t since the last reset fully determines the position.
    longint t           = 0;
    bit     model_valid = 1'b0;
    bit     tick_last   = 1'b0;
    bit     tk;
    bit     tgl         = 1'b0;

    always @(posedge clk) begin
`ifdef VGA_INTERNAL_TICK_EN
        tk = tgl;
`else
        tk = pix_tick;
`endif
        if (clr) begin
            t           = 0;
            tick_last   = 1'b0;
            model_valid = 1'b1;
            tgl         = 1'b0;
        end else begin
            tgl       = !tgl;
            tick_last = tk;
            if (tk) t = t + 1;
        end
    end

    function automatic void model_out(input longint tt, input int ht, input int vt,
                                      input int hd, input int hf, input int hs,
                                      input int vd, input int vf, input int vs,
                                      output int x, output int y,
                                      output bit ehs, output bit evs, output bit evo);
        longint f, p;
        f   = longint'(ht) * longint'(vt);
        p   = (tt + f - 1) % f;
        x   = int'(p % ht);
        y   = int'(p / ht);
        ehs = !((x >= hd + hf) && (x < hd + hf + hs));
        evs = !((y >= vd + vf) && (y < vd + vf + vs));
        evo = (x < hd) && (y < vd);
    endfunction

    task automatic cmp_dut(input string nm, input int ex, input int ey, input bit ehs,
                           input bit evs, input bit evo, input bit efs,
                           input logic [9:0] x, input logic [9:0] y, input logic hs,
                           input logic vs, input logic vo, input logic fs);
        n_checks++;
        if ((x !== 10'(ex)) || (y !== 10'(ey)) || (hs !== ehs) || (vs !== evs) ||
            (vo !== evo) || (fs !== efs)) begin
            n_fail++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL %s t=%0d got x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b want x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b",
                         nm, t, x, y, hs, vs, vo, fs, ex, ey, ehs, evs, evo, efs);
            end
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int ex, ey;
        bit ehs, evs, evo;
        if (model_valid) begin
            model_out(t, AHT, AVT, 640, 16, 96, 480, 10, 2, ex, ey, ehs, evs, evo);
            cmp_dut("cycle_a", ex, ey, ehs, evs, evo, tick_last && ex == 0 && ey == 0,
                    a_x, a_y, a_hs, a_vs, a_vo, a_fs);
            model_out(t, BHT, BVT, BHD, BHF, BHS, BVD, BVF, BVS, ex, ey, ehs, evs, evo);
            cmp_dut("cycle_b", ex, ey, ehs, evs, evo, tick_last && ex == 0 && ey == 0,
                    b_x, b_y, b_hs, b_vs, b_vo, b_fs);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Snapshot taken on the clk after each tick, plus running statistics.
    logic [9:0] sa_x, sa_y, sb_x, sb_y;
    logic       sa_vo, sa_fs, sb_vs, sb_fs;
    int tick_i = 0, hs_low_a = 0, vo_a = 0;
    int prev_fs_b = -1, last_period_b = 0, vlow_b = 0, last_vlow_b = 0;

    task automatic do_tick();
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
        sa_x = a_x; sa_y = a_y; sa_vo = a_vo; sa_fs = a_fs;
        sb_x = b_x; sb_y = b_y; sb_vs = b_vs; sb_fs = b_fs;
        if (a_y == 10'd0) begin
            if (!a_hs) hs_low_a++;
            if (a_vo) vo_a++;
        end
        if (b_fs) begin
            if (prev_fs_b >= 0) begin
                last_period_b = tick_i - prev_fs_b;
                last_vlow_b   = vlow_b;
            end
            prev_fs_b = tick_i;
            vlow_b    = 0;
        end
        if (!b_vs) vlow_b++;
        tick_i++;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        int mode;
        clr      = 1'b1;
        pix_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(a_x), 32'd799);
        chk("rst_y", 32'(a_y), 32'd524);
        chk("rst_hsync", 32'(a_hs), 32'd1);
        chk("rst_vsync", 32'(a_vs), 32'd1);
        chk("rst_video", 32'(a_vo), 32'd0);
        chk("rst_fs", 32'(a_fs), 32'd0);
        clr = 1'b0;

        do_tick();
        chk("first_x", 32'(sa_x), 32'd0);
        chk("first_y", 32'(sa_y), 32'd0);
        chk("first_video", 32'(sa_vo), 32'd1);
        chk("first_fs", 32'(sa_fs), 32'd1);
        chk("fs_no_repeat", 32'(a_fs), 32'd0);

        repeat (300) do_tick();
        chk("x_300", 32'(a_x), 32'd300);
        repeat (50) @(negedge clk);
        chk("hold_x", 32'(a_x), 32'd300);
        chk("hold_y", 32'(a_y), 32'd0);
        do_tick();
        chk("after_hold_x", 32'(sa_x), 32'd301);

        guard = 0;
        while (sa_y != 10'd1 && guard < 600) begin
            do_tick();
            guard++;
        end
        chk("wrap_x", 32'(sa_x), 32'd0);
        chk("wrap_y", 32'(sa_y), 32'd1);
        chk("hsync_low_ticks", 32'(hs_low_a), 32'd96);
        chk("video_ticks", 32'(vo_a), 32'd640);
        chk("b_frame_period", 32'(last_period_b), 32'd195);
        chk("b_vsync_low_ticks", 32'(last_vlow_b), 32'd30);

        // Reset during the last vsync line of the reduced instance, with a tick in the same cycle.
        guard = 0;
        while (!(sb_vs == 1'b0 && sb_y == 10'd9) && guard < 400) begin
            do_tick();
            guard++;
        end
        chk("reach_vsync_line", 32'(sb_y), 32'd9);
        clr      = 1'b1;
        pix_tick = 1'b1;
        @(negedge clk);
        chk("clr_b_x", 32'(b_x), 32'd14);
        chk("clr_b_y", 32'(b_y), 32'd12);
        chk("clr_b_vsync", 32'(b_vs), 32'd1);
        chk("clr_a_x", 32'(a_x), 32'd799);
        clr      = 1'b0;
        pix_tick = 1'b0;
        @(negedge clk);
        do_tick();
        chk("post_clr_b_x", 32'(sb_x), 32'd0);
        chk("post_clr_b_y", 32'(sb_y), 32'd0);
        chk("post_clr_b_fs", 32'(sb_fs), 32'd1);

        // Randomised tick patterns and occasional resets, checked every cycle by the model.
        mode = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i % 500 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0:       pix_tick = i[0];
                1:       pix_tick = 1'b1;
                default: pix_tick = ($urandom_range(0, 9) < 3);
            endcase
            clr = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
        end
        clr      = 1'b0;
        pix_tick = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
